// File: rtl/fir_coef_sequencer.sv
// Coefficient loader and sample feeder for the transposed FIR filter (fir_gen).
// Optional feature macro: ZERO_FLUSH_EN (zero-stuffed flush of the adder chain after a load).
module fir_coef_sequencer #(
   parameter int W1 = 8,
   parameter int L  = 3,
   localparam int CW = $clog2(L + 1),
   localparam int IW = (L > 2) ? $clog2(L) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W1-1:0] coef_data,
   input  logic          coef_valid,
   output logic          coef_ready,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [W1-1:0] s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          Load_x,
   output logic [W1-1:0] c_out,
   output logic [W1-1:0] x_out,
   output logic [1:0]    dbg_state,
   output logic [CW-1:0] dbg_count
);

   // Handshakes: a transfer happens on a rising clk edge where valid & ready are both 1;
   // ready depends only on state/count, never on valid, and valid may be held across cycles.

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
`ifdef ZERO_FLUSH_EN
   localparam logic [1:0] FLUSH = 2'd3;
`endif

   localparam logic [CW-1:0] L_CNT  = CW'(L);
   localparam logic [IW-1:0] L_LAST = IW'(L - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W1-1:0] buf_q [L];
   logic [W1-1:0] buf_d [L];
   logic          load_x_q, load_x_d;
   logic [W1-1:0] c_out_q, c_out_d;
   logic [W1-1:0] x_out_q, x_out_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          coef_acc;
   logic          s_acc;

   assign coef_ready = (state_q != LOAD) && (count_q < L_CNT);
   assign s_ready    = (state_q == RUN);
   assign coef_acc   = coef_valid && coef_ready;
   assign s_acc      = s_valid && s_ready;

   assign Load_x    = load_x_q;
   assign c_out     = c_out_q;
   assign x_out     = x_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;
   assign dbg_count = count_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idx_d    = idx_q;
      buf_d    = buf_q;
      load_x_d = load_x_q;
      c_out_d  = c_out_q;
      x_out_d  = x_out_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      // Buffer write is independent of the sample path in the same cycle.
      if (coef_acc) begin
         buf_d[count_q[IW-1:0]] = coef_data;
         count_d                = count_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            state_d  = RUN;
            load_x_d = 1'b1;
            x_out_d  = '0;
         end
         RUN: begin
            load_x_d = 1'b1;
            x_out_d  = s_acc ? s_data : '0;
            if (start && (count_q == L_CNT)) begin
               state_d  = LOAD;
               idx_d    = '0;
               load_x_d = 1'b0;
               c_out_d  = buf_q[0];
               busy_d   = 1'b1;
            end
         end
         LOAD: begin
            if (idx_q == L_LAST) begin
               count_d  = '0;
               load_x_d = 1'b1;
               done_d   = 1'b1;
               idx_d    = '0;
`ifdef ZERO_FLUSH_EN
               state_d  = FLUSH;
               busy_d   = 1'b1;
               x_out_d  = '0;
`else
               state_d  = RUN;
               busy_d   = 1'b0;
`endif
            end else begin
               idx_d   = idx_q + IW'(1);
               c_out_d = buf_q[idx_q + IW'(1)];
            end
         end
`ifdef ZERO_FLUSH_EN
         FLUSH: begin
            load_x_d = 1'b1;
            x_out_d  = '0;
            if (idx_q == L_LAST) begin
               state_d = RUN;
               busy_d  = 1'b0;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
`endif
         default: begin
            state_d  = IDLE;
            load_x_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   // Reset drops any buffered set; a load cut short leaves the filter for the host to reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         idx_q    <= '0;
         load_x_q <= 1'b1;
         c_out_q  <= '0;
         x_out_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int k = 0; k < L; k++) buf_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         idx_q    <= idx_d;
         load_x_q <= load_x_d;
         c_out_q  <= c_out_d;
         x_out_q  <= x_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         for (int k = 0; k < L; k++) buf_q[k] <= buf_d[k];
      end
   end

endmodule
